mux_nx1_arb: RTL and testbench
==============================

// Module: mux_nx1_arb
// PURPOSE
//  Parametrised N-channel to 1 selector with valid/ready handshakes and a registered output.
//  Each channel is granted either by a fixed select or by round-robin arbitration.
//  It sits between several producer streams and a single downstream consumer.
//  It replaces hard-wired 4:1 muxing wherever back-pressure or fair sharing is needed.
// PARAMETERS
//  N_CH   4  number of input channels (>=2); SEL_W = $clog2(N_CH) is a localparam
//  WIDTH  8  data bits per channel
// PORTS
//  clk       in   1            rising-edge clock; the only clock
//  rst_n     in   1            asynchronous, active-low reset
//  in_data   in   N_CH*WIDTH   channel k data is in_data[k*WIDTH +: WIDTH]
//  in_valid  in   N_CH         channel k presents a beat
//  in_ready  out  N_CH         channel k beat accepted this cycle (one-hot or zero)
//  mode      in   1            0 = fixed select, 1 = round-robin
//  sel       in   SEL_W        channel to use when mode = 0
//  out_data  out  WIDTH        registered selected data
//  out_ch    out  SEL_W        index of the channel that supplied out_data
//  out_valid out  1            out_data/out_ch hold a beat
//  out_ready in   1            consumer accepts the beat
// BEHAVIOUR
//  - Reset: asserting rst_n low clears the following immediately, independent of clk.
//    - Cleared to 0: out_valid, out_data, out_ch and the rr pointer ptr.
//    - A held beat is discarded.
//    - in_ready is 0 while in reset.
//  - load_en = !out_valid | out_ready. The output register may take a new beat when load_en is 1.
//  - Grant (combinational, evaluated every cycle):
//    - mode = 0: grant g = sel if in_valid[sel]. There is no grant if sel >= N_CH or in_valid[sel] = 0.
//    - mode = 1: g = the first k with in_valid[k] = 1, scanning ptr, ptr+1, ... N_CH-1, 0, ... ptr-1 (mod N_CH).
//  - in_ready[g] = load_en & grant_exists. All other in_ready bits are 0.
//  - Transfer on in_valid[g] & in_ready[g]. At the next clk edge:
//    - out_data <= channel g data, out_ch <= g, out_valid <= 1.
//  - Output handshake:
//    - If out_ready = 1 and no transfer occurs: out_valid <= 0. out_data and out_ch keep their values.
//    - While out_valid & !out_ready: out_data, out_ch and out_valid are held stable.
//  - Latency: 1 cycle from input acceptance to out_valid.
//    - Throughput: 1 beat per cycle when out_ready is held high.
//    - Simultaneous consume and load in the same cycle is allowed and gives no bubble.
//  - Pointer:
//    - Updates only on a transfer while mode = 1: ptr <= (g == N_CH-1) ? 0 : g+1.
//    - Unchanged in mode 0 and on cycles with no transfer.
//  - Mode or sel changes apply to the same-cycle grant. A held output beat is unaffected. ptr is preserved across mode changes.
//  - in_valid dropping without a transfer is legal, and no state changes.
//  - Data is passed unmodified. There is no width conversion.
// TESTING
//  1. mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1
//     -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
//  2. mode=0, sel=1, in_valid=4'b1101
//     -> in_ready=0 and out_valid stays 0. Also sel forced out of range (N_CH=3 build, sel=3) -> no grant.
//  3. mode=1, all in_valid=1, out_ready=1, 8 cycles
//     -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
//  4. mode=1, in_valid=4'b1010 held, ptr=0
//     -> grants 1,3,1,3. Then in_valid=4'b0001 -> grant 0.
//  5. Back-pressure: out_ready=0 with out_valid=1 for 5 cycles
//     -> out_data/out_ch stable, in_ready=0. Then out_ready=1 -> new beat loads the same cycle, no gap.
//  6. rst_n low mid-stream, asserted asynchronously between edges
//     -> out_valid, out_data, out_ch and in_ready go to 0 immediately.
//     -> After release, the first rr grant goes to the lowest valid channel at or after 0.

Source files
------------

// File: rtl/mux_nx1_arb.sv
// N-channel to 1 stream selector with fixed-select or round-robin grant and a
// registered, back-pressurable output stage.
module mux_nx1_arb #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int SEL_SPAN = 1 << SEL_W;

   logic [WIDTH-1:0]    ch_data [SEL_SPAN];
   logic [SEL_SPAN-1:0] valid_pad;
   logic [WIDTH-1:0]    out_data_reg;
   logic [SEL_W-1:0]    out_ch_reg;
   logic                out_valid_reg;
   logic [SEL_W-1:0]    ptr_reg;
   logic [SEL_W-1:0]    rr_g;
   logic                rr_ok;
   logic [SEL_W-1:0]    grant_g;
   logic                grant_ok;
   logic                load_en;
   logic                xfer;
   int                  idx;

   // Pad the channel space to a power of two so any sel value indexes safely;
   // padding lanes never hold a valid beat, so out-of-range sel cannot grant.
   genvar gi;
   generate
      for (gi = 0; gi < SEL_SPAN; gi++) begin : g_ch
         if (gi < N_CH) begin : g_used
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign ch_data[gi] = '0;
         end
      end
   endgenerate

   assign valid_pad = SEL_SPAN'(in_valid);

   always_comb begin
      rr_ok = 1'b0;
      rr_g  = '0;
      idx   = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = (int'(ptr_reg) + i) % N_CH;
         if (!rr_ok && in_valid[idx]) begin
            rr_ok = 1'b1;
            rr_g  = SEL_W'(idx);
         end
      end
   end

   assign grant_g  = mode ? rr_g  : sel;
   assign grant_ok = mode ? rr_ok : valid_pad[sel];
   assign load_en  = !out_valid_reg || out_ready;
   assign xfer     = rst_n && load_en && grant_ok;

   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_rdy
         assign in_ready[gi] = xfer && (grant_g == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_valid_reg <= 1'b0;
         ptr_reg       <= '0;
      end else if (xfer) begin
         out_data_reg  <= ch_data[grant_g];
         out_ch_reg    <= grant_g;
         out_valid_reg <= 1'b1;
         if (mode) begin
            ptr_reg <= (grant_g == SEL_W'(N_CH - 1)) ? '0 : grant_g + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed self-checking bench for mux_nx1_arb: a 4-channel instance for the
// main scenarios and a 3-channel instance for the out-of-range select case.
module tb_mux_nx1_arb;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;

   int n_checks;
   int n_fail;

   logic [7:0] ch_val [4];

   mux_nx1_arb #(.N_CH(4), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_nx1_arb #(.N_CH(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode(1'b0), .sel(sel3), .out_data(out_data3),
      .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = 2'd2;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      in_valid3 = 3'b111;
      sel3      = 2'd0;
      #12;
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
      in_valid  = 4'b0000;
      in_valid3 = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_fixed();
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
      tick();
      $display("fixed beat: ch=%0d data=%h valid=%b", out_ch, out_data, out_valid);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_out_valid got=%b exp=1", out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL fixed_out_data got=%h exp=a5", out_data); end
      n_checks++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL fixed_out_ch got=%0d exp=2", out_ch); end
      in_valid = 4'b0000;
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL drain_keep_data got=%h exp=a5", out_data); end
   endtask

   task automatic test_no_grant();
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
      #1;
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL nogrant_in_ready got=%b exp=0000", in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nogrant_out_valid got=%b exp=0", out_valid); end
      in_valid = 4'b0000;
      sel3 = 2'd3; in_valid3 = 3'b111;
      #1;
      n_checks++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL sel_oob_in_ready got=%b exp=000", in_ready3); end
      tick();
      n_checks++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL sel_oob_out_valid got=%b exp=0", out_valid3); end
      sel3 = 2'd2;
      #1;
      n_checks++; if (in_ready3 !== 3'b100) begin n_fail++; $display("FAIL n3_sel2_in_ready got=%b exp=100", in_ready3); end
      tick();
      n_checks++; if (out_data3 !== 8'h33 || out_ch3 !== 2'd2) begin n_fail++; $display("FAIL n3_sel2_out got=%h/%0d exp=33/2", out_data3, out_ch3); end
      in_valid3 = 3'b000;
   endtask

   task automatic test_rr_all();
      logic [3:0] exp_rdy;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_rdy = 4'b0001 << (i % 4);
         #1;
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_all_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy); end
         tick();
         $display("rr beat %0d: ch=%0d data=%h", i, out_ch, out_data);
         n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== ch_val[i % 4]) begin
            n_fail++; $display("FAIL rr_all_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_ch, out_data, i % 4, ch_val[i % 4]);
         end
      end
   endtask

   task automatic test_rr_sparse();
      logic [1:0] exp_ch [5];
      exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1; exp_ch[3] = 2'd3; exp_ch[4] = 2'd0;
      mode = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 4) ? 4'b1010 : 4'b0001;
         tick();
         $display("sparse beat %0d: ch=%0d", i, out_ch);
         n_checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch[i]) begin
            n_fail++; $display("FAIL rr_sparse[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_ch, exp_ch[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_valid = 4'b1111; mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
         tick();
         n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/11", i, out_valid, out_ch, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=0010", in_ready); end
      tick();
      $display("release beat: ch=%0d data=%h", out_ch, out_data);
      n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) begin
         n_fail++; $display("FAIL bp_release_out got=%b/%0d/%h exp=1/1/22", out_valid, out_ch, out_data);
      end
   endtask

   task automatic test_async_reset();
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      tick();
      n_checks++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL pre_reset_ch got=%0d exp=2", out_ch); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
         n_fail++; $display("FAIL async_reset_out got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_ch);
      end
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL async_reset_in_ready got=%b exp=0000", in_ready); end
      tick();
      in_valid = 4'b1100;
      #2;
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=0100", in_ready); end
      tick();
      $display("post reset beat: ch=%0d data=%h", out_ch, out_data);
      n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin
         n_fail++; $display("FAIL post_reset_out got=%b/%0d exp=1/2", out_valid, out_ch);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'hA5; ch_val[3] = 8'h44;
      in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_data3 = {8'h33, 8'h22, 8'h11};
      test_reset();
      test_fixed();
      test_no_grant();
      test_rr_all();
      test_rr_sparse();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
